// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, ALU operand addresses and decoder state encoding for the
// system-control command path.
package sys_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_ALU_OPA,
      ST_ALU_OPB,
      ST_ALU_FUN
   } state_t;

   localparam logic [7:0] CMD_RF_WR   = 8'hAA;
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int unsigned ALU_OPA_ADDR = 0;
   localparam int unsigned ALU_OPB_ADDR = 1;

   // Maps a command byte to the first payload state; unknown bytes map to ST_IDLE.
   function automatic state_t cmd_target(input logic [7:0] cmd);
      state_t st;
      case (cmd)
         CMD_RF_WR:   st = ST_WR_ADDR;
         CMD_RF_RD:   st = ST_RD_ADDR;
         CMD_ALU_OP:  st = ST_ALU_OPA;
         CMD_ALU_NOP: st = ST_ALU_FUN;
         default:     st = ST_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte gap counter for cmd_frame_decoder; only instantiated when
// CMD_TIMEOUT_EN is defined.
module frame_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Expiry fires on the TIMEOUT_CYCLES-th consecutive gap cycle; a byte arriving
   // in that same cycle wins.
   assign expire_o = run_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i || !run_i || expire_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Decodes UART command frames into register-file and ALU strobes.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_frame_decoder
   import sys_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic                  RF_WR_EN,
   output logic                  RF_RD_EN,
   output logic [ADDR_WIDTH-1:0] RF_ADDR,
   output logic [DATA_WIDTH-1:0] RF_WR_DATA,
   output logic                  ALU_EN,
   output logic [3:0]            ALU_FUN,
   output logic                  BUSY,
   output logic                  CMD_ERR
);

   state_t                  state_q;
   state_t                  cmd_state_d;
   logic [ADDR_WIDTH-1:0]   byte_addr_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q;
   logic                    rf_wr_en_q;
   logic                    rf_rd_en_q;
   logic [ADDR_WIDTH-1:0]   rf_addr_q;
   logic [DATA_WIDTH-1:0]   rf_wr_data_q;
   logic                    alu_en_q;
   logic [3:0]              alu_fun_q;
   logic                    busy_q;
   logic                    cmd_err_q;

   assign cmd_state_d = cmd_target(8'(RX_P_DATA));
   assign byte_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];

`ifdef CMD_TIMEOUT_EN
   logic timeout_hit;

   frame_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (CLK),
      .rst_i    (RST),
      .clr_i    (RX_D_VLD),
      .run_i    (busy_q),
      .expire_o (timeout_hit)
   );
`endif

   // The write address is held privately until the data byte so RF_ADDR only
   // changes together with a strobe.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_en_q   <= 1'b0;
         rf_addr_q    <= '0;
         rf_wr_data_q <= '0;
         alu_en_q     <= 1'b0;
         alu_fun_q    <= '0;
         busy_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         rf_wr_en_q <= 1'b0;
         rf_rd_en_q <= 1'b0;
         alu_en_q   <= 1'b0;
         cmd_err_q  <= 1'b0;
         if (RX_D_VLD) begin
            case (state_q)
               ST_IDLE: begin
                  state_q   <= cmd_state_d;
                  busy_q    <= (cmd_state_d != ST_IDLE);
                  cmd_err_q <= (cmd_state_d == ST_IDLE);
               end
               ST_WR_ADDR: begin
                  wr_addr_q <= byte_addr_d;
                  state_q   <= ST_WR_DATA;
               end
               ST_WR_DATA: begin
                  rf_wr_en_q   <= 1'b1;
                  rf_addr_q    <= wr_addr_q;
                  rf_wr_data_q <= RX_P_DATA;
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
               end
               ST_RD_ADDR: begin
                  rf_rd_en_q <= 1'b1;
                  rf_addr_q  <= byte_addr_d;
                  state_q    <= ST_IDLE;
                  busy_q     <= 1'b0;
               end
               ST_ALU_OPA: begin
                  rf_wr_en_q   <= 1'b1;
                  rf_addr_q    <= ADDR_WIDTH'(ALU_OPA_ADDR);
                  rf_wr_data_q <= RX_P_DATA;
                  state_q      <= ST_ALU_OPB;
               end
               ST_ALU_OPB: begin
                  rf_wr_en_q   <= 1'b1;
                  rf_addr_q    <= ADDR_WIDTH'(ALU_OPB_ADDR);
                  rf_wr_data_q <= RX_P_DATA;
                  state_q      <= ST_ALU_FUN;
               end
               ST_ALU_FUN: begin
                  alu_en_q  <= 1'b1;
                  alu_fun_q <= RX_P_DATA[3:0];
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
`ifdef CMD_TIMEOUT_EN
         else if (timeout_hit) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b1;
         end
`endif
      end
   end

   assign RF_WR_EN   = rf_wr_en_q;
   assign RF_RD_EN   = rf_rd_en_q;
   assign RF_ADDR    = rf_addr_q;
   assign RF_WR_DATA = rf_wr_data_q;
   assign ALU_EN     = alu_en_q;
   assign ALU_FUN    = alu_fun_q;
   assign BUSY       = busy_q;
   assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Self-checking bench for cmd_frame_decoder against a frame-level reference model.
// Define CMD_TIMEOUT_EN to also exercise the inter-byte timeout (limit 16).
module tb_cmd_frame_decoder;

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TO = 16;
`else
   localparam int unsigned TO = 4096;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] RX_P_DATA = '0;
   logic       RX_D_VLD = 1'b0;
   logic       RF_WR_EN, RF_RD_EN, ALU_EN, BUSY, CMD_ERR;
   logic [3:0] RF_ADDR, ALU_FUN;
   logic [7:0] RF_WR_DATA;

   cmd_frame_decoder #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_P_DATA  (RX_P_DATA),
      .RX_D_VLD   (RX_D_VLD),
      .RF_WR_EN   (RF_WR_EN),
      .RF_RD_EN   (RF_RD_EN),
      .RF_ADDR    (RF_ADDR),
      .RF_WR_DATA (RF_WR_DATA),
      .ALU_EN     (ALU_EN),
      .ALU_FUN    (ALU_FUN),
      .BUSY       (BUSY),
      .CMD_ERR    (CMD_ERR)
   );

   always #5 CLK = ~CLK;

   int check_cnt = 0;
   int err_cnt   = 0;

   // Reference model: current command byte (0 = none) and payload bytes seen.
   int         m_cmd, m_idx, m_gap;
   logic [3:0] m_addr_latch;
   logic       exp_wr, exp_rd, exp_alu, exp_err, exp_busy;
   logic [3:0] exp_addr, exp_fun;
   logic [7:0] exp_wdata;

   logic [20:0] obs, expv;
   assign obs  = {RF_WR_EN, RF_RD_EN, ALU_EN, CMD_ERR, BUSY, RF_ADDR, RF_WR_DATA, ALU_FUN};
   assign expv = {exp_wr, exp_rd, exp_alu, exp_err, exp_busy, exp_addr, exp_wdata, exp_fun};

   function automatic int payload_len(input int cmd);
      case (cmd)
         'hAA:    return 2;
         'hCC:    return 3;
         default: return 1;
      endcase
   endfunction

   function void model_reset();
      m_cmd = 0; m_idx = 0; m_gap = 0; m_addr_latch = '0;
      exp_wr = 0; exp_rd = 0; exp_alu = 0; exp_err = 0; exp_busy = 0;
      exp_addr = '0; exp_fun = '0; exp_wdata = '0;
   endfunction

   function void model_step(input logic v, input logic [7:0] d);
      exp_wr = 0; exp_rd = 0; exp_alu = 0; exp_err = 0;
      if (v) begin
         m_gap = 0;
         if (m_cmd == 0) begin
            if (d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
               m_cmd = int'(d);
               m_idx = 0;
            end else begin
               exp_err = 1;
            end
         end else begin
            case (m_cmd)
               'hAA: if (m_idx == 0) m_addr_latch = d[3:0];
                     else begin exp_wr = 1; exp_addr = m_addr_latch; exp_wdata = d; end
               'hBB: begin exp_rd = 1; exp_addr = d[3:0]; end
               'hCC: if (m_idx < 2) begin
                        exp_wr = 1; exp_addr = (m_idx == 0) ? 4'd0 : 4'd1; exp_wdata = d;
                     end else begin
                        exp_alu = 1; exp_fun = d[3:0];
                     end
               default: begin exp_alu = 1; exp_fun = d[3:0]; end
            endcase
            m_idx++;
            if (m_idx == payload_len(m_cmd)) m_cmd = 0;
         end
      end
`ifdef CMD_TIMEOUT_EN
      else if (m_cmd != 0) begin
         m_gap++;
         if (m_gap == int'(TO)) begin
            m_cmd = 0; m_gap = 0; exp_err = 1;
         end
      end
`endif
      exp_busy = (m_cmd != 0);
   endfunction

   // Called at posedge+1; returns at the next posedge+1 with outputs settled.
   task automatic send(input logic v, input logic [7:0] d);
      RX_D_VLD  = v;
      RX_P_DATA = v ? d : 8'($urandom);
      model_step(v, d);
      @(posedge CLK);
      #1;
      RX_D_VLD = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      check_cnt++;
      if (obs !== expv) begin
         err_cnt++;
         $display("FAIL reset_state: got %h expected %h", obs, expv);
      end
      RST = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_write();
      logic [7:0] seq [4] = '{8'hAA, 8'h05, 8'h05, 8'h00};
      logic       vld [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      int wr_pulses = 0;
      for (int i = 0; i < 4; i++) begin
         send(vld[i], seq[i]);
         if (RF_WR_EN === 1'b1) wr_pulses++;
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL write step %0d: got %h expected %h", i, obs, expv);
         end
      end
      check_cnt++;
      if (wr_pulses != 1) begin
         err_cnt++;
         $display("FAIL write_pulse_count: got %0d expected 1", wr_pulses);
      end
   endtask

   task automatic test_read();
      logic [7:0] seq [3] = '{8'hBB, 8'h05, 8'h00};
      logic       vld [3] = '{1'b1, 1'b1, 1'b0};
      int rd_pulses = 0;
      int wr_pulses = 0;
      for (int i = 0; i < 3; i++) begin
         send(vld[i], seq[i]);
         if (RF_RD_EN === 1'b1) rd_pulses++;
         if (RF_WR_EN === 1'b1) wr_pulses++;
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL read step %0d: got %h expected %h", i, obs, expv);
         end
      end
      check_cnt++;
      if (rd_pulses != 1 || wr_pulses != 0) begin
         err_cnt++;
         $display("FAIL read_pulse_count: got rd=%0d wr=%0d expected rd=1 wr=0", rd_pulses, wr_pulses);
      end
   endtask

   task automatic test_alu_ops();
      logic [7:0] seq [5] = '{8'hCC, 8'h03, 8'h03, 8'h00, 8'h00};
      logic       vld [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         send(vld[i], seq[i]);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL alu_ops step %0d: got %h expected %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_err_then_nop();
      logic [7:0] seq [5] = '{8'h12, 8'h00, 8'hDD, 8'h01, 8'h00};
      logic       vld [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         send(vld[i], seq[i]);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL err_nop step %0d: got %h expected %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] seq [3] = '{8'hBB, 8'h07, 8'h00};
      logic       vld [3] = '{1'b1, 1'b1, 1'b0};
      send(1'b1, 8'hAA);
      send(1'b1, 8'h05);
      check_cnt++;
      if (BUSY !== 1'b1) begin
         err_cnt++;
         $display("FAIL midframe_busy: got %b expected 1", BUSY);
      end
      #2;
      RST = 1'b1;
      model_reset();
      #1;
      check_cnt++;
      if (obs !== expv) begin
         err_cnt++;
         $display("FAIL async_reset: got %h expected %h", obs, expv);
      end
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      send(1'b1, 8'h05);
      check_cnt++;
      if (obs !== expv) begin
         err_cnt++;
         $display("FAIL post_reset_first_byte: got %h expected %h", obs, expv);
      end
      for (int i = 0; i < 3; i++) begin
         send(vld[i], seq[i]);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL reset_resume step %0d: got %h expected %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [12] = '{8'hCC, 8'h11, 8'h22, 8'h03, 8'hAA, 8'h0F, 8'hAA,
                               8'hBB, 8'hCC, 8'hDD, 8'hDD, 8'h00};
      for (int i = 0; i < 12; i++) begin
         send(i != 11, seq[i]);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, expv);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] cmds [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      logic [7:0] d;
      logic       v;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
         send(v, d);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL random step %0d: got %h expected %h", i, obs, expv);
         end
      end
   endtask

`ifdef CMD_TIMEOUT_EN
   task automatic test_timeout();
      send(1'b1, 8'hAA);
      for (int i = 0; i < int'(TO) + 1; i++) begin
         send(i == int'(TO), 8'h05);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL timeout step %0d: got %h expected %h", i, obs, expv);
         end
      end
      send(1'b1, 8'hAA);
      for (int i = 0; i < int'(TO) + 1; i++) begin
         send(i >= int'(TO) - 1, (i == int'(TO) - 1) ? 8'h03 : 8'h07);
         check_cnt++;
         if (obs !== expv) begin
            err_cnt++;
            $display("FAIL timeout_priority step %0d: got %h expected %h", i, obs, expv);
         end
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      model_reset();
      #12;
      test_reset();
      test_write();
      test_read();
      test_alu_ops();
      test_err_then_nop();
      test_reset_midframe();
      test_back_to_back();
`ifdef CMD_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
